xyz_cmd_sequencer: RTL and testbench

Upstream command sequencer feeding the xyz stage.
- Buffers commands from a valid/ready source in a small FIFO.
- Drives xyz inputs signal_b[2:0] and signal_e for a programmed hold time.
- Waits for the xyz response signal_f, then reports completion or timeout on a one-cycle done strobe.

---
 rtl/xyz_cmd_sequencer_if.sv | 22 ++
 rtl/xyz_cmd_sequencer.sv | 159 +++++++++++++++
 tb/tb_xyz_cmd_sequencer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/xyz_cmd_sequencer_if.sv
// Command handshake and completion bundle between a command source and xyz_cmd_sequencer.
interface xyz_cmd_sequencer_if #(
   parameter int HOLD_W = 4
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [2:0]        cmd_b;
   logic              cmd_e;
   logic [HOLD_W-1:0] cmd_hold;
   logic              done_valid;
   logic [1:0]        done_status;

   modport master (
      output cmd_valid, cmd_b, cmd_e, cmd_hold,
      input  cmd_ready, done_valid, done_status
   );

   modport slave (
      input  cmd_valid, cmd_b, cmd_e, cmd_hold,
      output cmd_ready, done_valid, done_status
   );
endinterface

// File: rtl/xyz_cmd_sequencer.sv
// Queues commands, drives signal_b/signal_e for a programmed hold time, then waits for
// signal_f (or times out) and strobes done.
//
// state  | meaning
// IDLE   | outputs at 0, pop FIFO head when one is queued
// DRIVE  | hold b/e for cmd_hold+1 cycles
// WAIT   | hold b/e until signal_f or TIMEOUT cycles elapse
// REPORT | done_valid strobe, b/e released on exit
module xyz_cmd_sequencer #(
   parameter int DEPTH   = 4,
   parameter int HOLD_W  = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                  clk,
   input  logic                  rst_n,
   xyz_cmd_sequencer_if.slave    bus,
   input  logic                  flush,
   output logic [2:0]            signal_b,
   output logic                  signal_e,
   input  logic                  signal_f,
   output logic                  busy
);
   localparam int AW = $clog2(DEPTH);
   localparam int EW = 4 + HOLD_W;
   localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
   localparam logic [7:0]  WAIT_LOAD = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, DRIVE, WAIT, REPORT} state_t;

   state_t            state_q, state_d;
   logic [EW-1:0]     mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [AW:0]       count, count_d;
   logic              full, empty, push, pop;
   logic [EW-1:0]     head;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [7:0]        wait_q, wait_d;
   logic [2:0]        b_d;
   logic              e_d;
   logic [1:0]        status_d;
   logic              busy_d;

   assign full          = (count == FULL_CNT);
   assign empty         = (count == '0);
   assign bus.cmd_ready = !full;
   assign push          = bus.cmd_valid && !full && !flush;
   assign head          = mem[rd_ptr];
   // flush in the REPORT cycle swallows the strobe
   assign bus.done_valid = (state_q == REPORT) && !flush;

   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      wait_d   = wait_q;
      b_d      = signal_b;
      e_d      = signal_e;
      status_d = bus.done_status;
      pop      = 1'b0;
      case (state_q)
         IDLE: begin
            b_d = 3'd0;
            e_d = 1'b0;
            if (!empty) begin
               pop     = 1'b1;
               b_d     = head[EW-1 -: 3];
               e_d     = head[HOLD_W];
               hold_d  = head[HOLD_W-1:0];
               state_d = DRIVE;
            end
         end
         DRIVE: begin
            if (hold_q == '0) begin
               state_d = WAIT;
               wait_d  = WAIT_LOAD;
            end else begin
               hold_d = hold_q - 1'b1;
            end
         end
         WAIT: begin
            if (signal_f) begin
               state_d  = REPORT;
               status_d = 2'b00;
            end else if (wait_q == '0) begin
               state_d  = REPORT;
               status_d = 2'b01;
            end else begin
               wait_d = wait_q - 1'b1;
            end
         end
         REPORT: begin
            state_d = IDLE;
            b_d     = 3'd0;
            e_d     = 1'b0;
         end
         default: state_d = IDLE;
      endcase

      if (flush) begin
         state_d = IDLE;
         b_d     = 3'd0;
         e_d     = 1'b0;
         pop     = 1'b0;
      end

      count_d = count;
      if (flush)
         count_d = '0;
      else if (push && !pop)
         count_d = count + 1'b1;
      else if (pop && !push)
         count_d = count - 1'b1;

      busy_d = (state_d != IDLE) || (count_d != '0);
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {bus.cmd_b, bus.cmd_e, bus.cmd_hold};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push)
               wr_ptr <= wr_ptr + 1'b1;
            if (pop)
               rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         hold_q          <= '0;
         wait_q          <= '0;
         signal_b        <= 3'd0;
         signal_e        <= 1'b0;
         bus.done_status <= 2'b00;
         busy            <= 1'b0;
      end else begin
         state_q         <= state_d;
         hold_q          <= hold_d;
         wait_q          <= wait_d;
         signal_b        <= b_d;
         signal_e        <= e_d;
         bus.done_status <= status_d;
         busy            <= busy_d;
      end
   end
endmodule

// File: tb/tb_xyz_cmd_sequencer.sv
// Randomized bench for xyz_cmd_sequencer against a queue-plus-elapsed-time reference model.
module tb_xyz_cmd_sequencer;
   localparam int DEPTH   = 4;
   localparam int HOLD_W  = 4;
   localparam int TIMEOUT = 15;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       flush;
   logic       signal_f;
   logic [2:0] signal_b;
   logic       signal_e;
   logic       busy;

   xyz_cmd_sequencer_if #(.HOLD_W(HOLD_W)) bus ();

   xyz_cmd_sequencer #(.DEPTH(DEPTH), .HOLD_W(HOLD_W), .TIMEOUT(TIMEOUT)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .flush    (flush),
      .signal_b (signal_b),
      .signal_e (signal_e),
      .signal_f (signal_f),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] b;
      logic       e;
      int         hold;
   } cmd_t;

   // model: pending queue, the command in service and cycles elapsed since its pop
   cmd_t       q[$];
   cmd_t       cur;
   bit         active;
   bit         in_rep;
   int         t;
   logic [1:0] m_status;

   int total = 0;
   int bad = 0;
   int done_seen = 0;
   int push_cnt = 0;
   int b5_cycles = 0;
   int d0, p0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_reset();
      q.delete();
      active   = 1'b0;
      in_rep   = 1'b0;
      t        = 0;
      m_status = 2'b00;
   endfunction

   task automatic step(input logic v, input logic [2:0] b, input logic e,
                       input logic [HOLD_W-1:0] h, input logic f, input logic fl);
      cmd_t c;
      bit   can_push;
      bus.cmd_valid = v;
      bus.cmd_b     = b;
      bus.cmd_e     = e;
      bus.cmd_hold  = h;
      signal_f      = f;
      flush         = fl;
      #1;
      can_push = (q.size() < DEPTH);
      check_val("cmd_ready", 32'(bus.cmd_ready), 32'(can_push));
      check_val("done_valid", 32'(bus.done_valid), 32'(in_rep && !fl));
      if (bus.done_valid === 1'b1) done_seen++;
      @(posedge clk);
      if (fl) begin
         q.delete();
         active = 1'b0;
         in_rep = 1'b0;
      end else begin
         if (in_rep) begin
            in_rep = 1'b0;
         end else if (active) begin
            if (t <= cur.hold) begin
               t++;
            end else if (f) begin
               active = 1'b0; in_rep = 1'b1; m_status = 2'b00;
            end else if (t - cur.hold - 1 == TIMEOUT - 1) begin
               active = 1'b0; in_rep = 1'b1; m_status = 2'b01;
            end else begin
               t++;
            end
         end else if (q.size() > 0) begin
            cur    = q.pop_front();
            active = 1'b1;
            t      = 0;
         end
         if (v && can_push) begin
            c.b = b; c.e = e; c.hold = int'(h);
            q.push_back(c);
            push_cnt++;
         end
      end
      @(negedge clk);
      check_val("signal_b", 32'(signal_b), 32'((active || in_rep) ? cur.b : 3'd0));
      check_val("signal_e", 32'(signal_e), 32'((active || in_rep) ? cur.e : 1'b0));
      check_val("done_status", 32'(bus.done_status), 32'(m_status));
      check_val("busy", 32'(busy), 32'(active || in_rep || q.size() != 0));
      if (signal_b == 3'd5) b5_cycles++;
   endtask

   task automatic idle_steps(input int n, input logic f);
      for (int i = 0; i < n; i++) step(1'b0, 3'd0, 1'b0, '0, f, 1'b0);
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_b     = 3'd0;
      bus.cmd_e     = 1'b0;
      bus.cmd_hold  = '0;
      signal_f      = 1'b0;
      flush         = 1'b0;
      model_reset();
      #1;
      check_val("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_signal_b", 32'(signal_b), 32'd0);
      check_val("rst_done_valid", 32'(bus.done_valid), 32'd0);
      check_val("rst_done_status", 32'(bus.done_status), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // single command, signal_f on the second WAIT cycle
      d0 = done_seen;
      b5_cycles = 0;
      step(1'b1, 3'b101, 1'b1, 4'd2, 1'b0, 1'b0);
      for (int i = 1; i < 10; i++) step(1'b0, 3'd0, 1'b0, '0, (i == 6), 1'b0);
      check_val("single_done_cnt", 32'(done_seen - d0), 32'd1);
      check_val("single_b5_cycles", 32'(b5_cycles), 32'd6);

      // timeout
      d0 = done_seen;
      step(1'b1, 3'b011, 1'b0, 4'd0, 1'b0, 1'b0);
      idle_steps(22, 1'b0);
      check_val("timeout_done_cnt", 32'(done_seen - d0), 32'd1);
      check_val("timeout_status", 32'(bus.done_status), 32'd1);

      // backpressure: five back-to-back pushes into a four-deep FIFO
      d0 = done_seen;
      p0 = push_cnt;
      for (int i = 0; i < 60 && push_cnt - p0 < 5; i++)
         step(1'b1, 3'(push_cnt - p0 + 1), 1'(push_cnt - p0), 4'd3, 1'b1, 1'b0);
      check_val("bp_accepts", 32'(push_cnt - p0), 32'd5);
      idle_steps(40, 1'b1);
      check_val("bp_done_cnt", 32'(done_seen - d0), 32'd5);

      // flush during WAIT with two commands still queued
      d0 = done_seen;
      step(1'b1, 3'd1, 1'b1, 4'd1, 1'b0, 1'b0);
      step(1'b1, 3'd2, 1'b0, 4'd1, 1'b0, 1'b0);
      step(1'b1, 3'd3, 1'b1, 4'd1, 1'b0, 1'b0);
      idle_steps(2, 1'b0);
      step(1'b0, 3'd0, 1'b0, '0, 1'b1, 1'b1);
      check_val("flush_busy", 32'(busy), 32'd0);
      check_val("flush_done_cnt", 32'(done_seen - d0), 32'd0);
      step(1'b1, 3'd6, 1'b1, 4'd0, 1'b0, 1'b0);
      idle_steps(6, 1'b1);
      check_val("post_flush_done_cnt", 32'(done_seen - d0), 32'd1);

      // asynchronous reset in the middle of DRIVE
      step(1'b1, 3'd7, 1'b1, 4'd15, 1'b0, 1'b0);
      idle_steps(3, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check_val("arst_signal_b", 32'(signal_b), 32'd0);
      check_val("arst_signal_e", 32'(signal_e), 32'd0);
      check_val("arst_busy", 32'(busy), 32'd0);
      check_val("arst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check_val("arst_done_valid", 32'(bus.done_valid), 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      d0 = done_seen;
      b5_cycles = 0;
      step(1'b1, 3'd5, 1'b0, 4'd0, 1'b0, 1'b0);
      step(1'b0, 3'd0, 1'b0, '0, 1'b0, 1'b0);
      step(1'b0, 3'd0, 1'b0, '0, 1'b0, 1'b0);
      step(1'b0, 3'd0, 1'b0, '0, 1'b1, 1'b0);
      idle_steps(2, 1'b0);
      // one DRIVE cycle, one WAIT cycle, one REPORT cycle
      check_val("arst_h0_b5_cycles", 32'(b5_cycles), 32'd3);
      check_val("arst_h0_done_cnt", 32'(done_seen - d0), 32'd1);

      // randomized traffic
      for (int i = 0; i < 700; i++) begin
         logic [HOLD_W-1:0] h;
         h = ($urandom % 4 == 0) ? HOLD_W'($urandom_range(0, 15)) : HOLD_W'($urandom_range(0, 3));
         step(1'($urandom % 2), 3'($urandom), 1'($urandom), h,
              1'($urandom % 3 == 0), 1'($urandom % 40 == 0));
      end
      idle_steps(40, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
